// File: rtl/score_tracker.sv
// score_tracker: live 4-digit BCD score, session high score and display-select flag.
// Latency: every output is registered; an input sampled at edge N is visible after edge N
// (the show button reaches displayState at its 3rd sampled-high edge). No backpressure.
module score_tracker #(
  parameter int SHOW_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clear_score,
  input  logic       show_btn,
  output logic [3:0] BCD3,
  output logic [3:0] BCD2,
  output logic [3:0] BCD1,
  output logic [3:0] BCD0,
  output logic [3:0] HS3,
  output logic [3:0] HS2,
  output logic [3:0] HS1,
  output logic [3:0] HS0,
  output logic       displayState,
  output logic       new_high
);

  // Timer only needs to hold SHOW_CYCLES-1.
  localparam int TW = (SHOW_CYCLES > 2) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(SHOW_CYCLES - 1);

  logic [15:0]   score;
  logic [15:0]   hs;
  logic [3:0]    digit    [4];
  logic [3:0]    digit_nx [4];
  logic          carry;
  logic          at_max;
  logic          is_higher;
  logic          sync1;
  logic          sync2;
  logic          prev;
  logic          show_rise;
  logic [TW-1:0] timer;

  assign score = {BCD3, BCD2, BCD1, BCD0};
  assign hs    = {HS3, HS2, HS1, HS0};

  // Packed BCD keeps numeric order, so one unsigned compare equals the
  // digit-wise compare from the most significant digit.
  assign is_higher = (score > hs);
  assign at_max    = (score == 16'h9999);
  assign show_rise = sync2 & ~prev;

  // Decimal +1 with ripple carry from units upward; saturation handled by the register.
  always_comb begin
    digit[0] = BCD0;
    digit[1] = BCD1;
    digit[2] = BCD2;
    digit[3] = BCD3;
    carry    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      digit_nx[i] = digit[i];
      if (carry) begin
        if (digit[i] == 4'd9) begin
          digit_nx[i] = 4'd0;
        end else begin
          digit_nx[i] = digit[i] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
  end

  // Score register: clear wins over inc, inc holds at 9999.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {BCD3, BCD2, BCD1, BCD0} <= 16'h0000;
    end else if (clear_score) begin
      {BCD3, BCD2, BCD1, BCD0} <= 16'h0000;
    end else if (inc && !at_max) begin
      {BCD3, BCD2, BCD1, BCD0} <= {digit_nx[3], digit_nx[2], digit_nx[1], digit_nx[0]};
    end
  end

  // High-score commit using the pre-edge score, with a one-cycle new_high pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {HS3, HS2, HS1, HS0} <= 16'h0000;
      new_high             <= 1'b0;
    end else begin
      new_high <= clear_score && is_higher;
      if (clear_score && is_higher) begin
        {HS3, HS2, HS1, HS0} <= score;
      end
    end
  end

  // Two-flop synchroniser for the raw button plus a delayed copy for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= show_btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // View timer: each rising edge (re)starts a SHOW_CYCLES-long high-score view.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      displayState <= 1'b0;
      timer        <= '0;
    end else if (show_rise) begin
      displayState <= 1'b1;
      timer        <= TIMER_LOAD;
    end else if (displayState) begin
      if (timer == '0) begin
        displayState <= 1'b0;
      end else begin
        timer <= timer - TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_score_tracker.sv
// Bench for score_tracker: an integer reference model pushes the expected
// output word at every clock edge; a negedge monitor pops and compares it.
// Directed checks cover reset, digit values, commit pulses and view timing.
module tb_score_tracker;

  localparam int SC = 8;

  logic       clk;
  logic       rst;
  logic       inc;
  logic       clear_score;
  logic       show_btn;
  logic [3:0] BCD3, BCD2, BCD1, BCD0;
  logic [3:0] HS3, HS2, HS1, HS0;
  logic       displayState;
  logic       new_high;

  int n_checks = 0;
  int n_errors = 0;

  logic [33:0] exp_q[$];
  int          m_score;
  int          m_hs;
  int          m_rem;
  bit          s1, s2, s3;

  wire [15:0] bcd = {BCD3, BCD2, BCD1, BCD0};
  wire [15:0] hsv = {HS3, HS2, HS1, HS0};
  wire [33:0] obs = {bcd, hsv, displayState, new_high};

  score_tracker #(.SHOW_CYCLES(SC)) dut (
    .clk          (clk),
    .rst          (rst),
    .inc          (inc),
    .clear_score  (clear_score),
    .show_btn     (show_btn),
    .BCD3         (BCD3),
    .BCD2         (BCD2),
    .BCD1         (BCD1),
    .BCD0         (BCD0),
    .HS3          (HS3),
    .HS2          (HS2),
    .HS1          (HS1),
    .HS0          (HS0),
    .displayState (displayState),
    .new_high     (new_high)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Reference model: evaluated on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    bit nh;
    bit rise;
    if (!rst) begin
      nh = 1'b0;
      if (clear_score) begin
        if (m_score > m_hs) begin
          m_hs = m_score;
          nh   = 1'b1;
        end
        m_score = 0;
      end else if (inc && m_score < 9999) begin
        m_score++;
      end
      // Button sample from two edges ago is high, three edges ago low.
      rise = s2 && !s3;
      s3 = s2;
      s2 = s1;
      s1 = show_btn;
      if (rise) m_rem = SC;
      else if (m_rem > 0) m_rem--;
      exp_q.push_back({to_bcd(m_score), to_bcd(m_hs), (m_rem > 0), nh});
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cycle", 64'(obs), 64'(e));
    end
  end

  task automatic pulse_inc(input int n);
    repeat (n) begin
      @(negedge clk);
      inc = 1'b1;
    end
    @(negedge clk);
    inc = 1'b0;
  endtask

  task automatic commit_chk(input bit with_inc, input bit exp_nh, input logic [15:0] exp_hs);
    @(negedge clk);
    clear_score = 1'b1;
    inc         = with_inc;
    @(negedge clk);
    clear_score = 1'b0;
    inc         = 1'b0;
    chk("commit_nh", 64'(new_high), 64'(exp_nh));
    chk("commit_hs", 64'(hsv), 64'(exp_hs));
    chk("commit_bcd", 64'(bcd), 64'h0);
    @(negedge clk);
    chk("nh_one_cycle", 64'(new_high), 64'h0);
  endtask

  // Called at a negedge; asserts reset between edges and checks it acts at once.
  task automatic async_reset();
    show_btn    = 1'b0;
    inc         = 1'b0;
    clear_score = 1'b0;
    #2 rst = 1'b1;
    #1 chk("rst_async", 64'(obs), 64'h0);
    exp_q.delete();
    m_score = 0;
    m_hs    = 0;
    m_rem   = 0;
    s1 = 0; s2 = 0; s3 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hold", 64'(obs), 64'h0);
  endtask

  // Starts a view; optionally re-pulses the button at view cycle 'retrig'.
  task automatic show_view(input int hold, input int retrig, output int first, output int len);
    first = 0;
    len   = 0;
    @(negedge clk);
    show_btn = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == hold) show_btn = 1'b0;
      if (displayState) begin
        if (len == 0) first = i;
        len++;
        if (len == retrig) show_btn = 1'b1;
        else if (retrig > 0 && len == retrig + 1) show_btn = 1'b0;
      end
    end
    show_btn = 1'b0;
  endtask

  int f1, l1;

  initial begin
    rst         = 1'b1;
    inc         = 1'b0;
    clear_score = 1'b0;
    show_btn    = 1'b0;
    m_score = 0; m_hs = 0; m_rem = 0;
    repeat (2) @(negedge clk);
    chk("reset_state", 64'(obs), 64'h0);
    rst = 1'b0;

    // Mid-operation reset: score 0042, HS 0107, view active.
    pulse_inc(107);
    commit_chk(1'b0, 1'b1, 16'h0107);
    pulse_inc(42);
    @(negedge clk);
    show_btn = 1'b1;
    @(negedge clk);
    show_btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_view", 64'({bcd, hsv, displayState}), 64'({16'h0042, 16'h0107, 1'b1}));
    async_reset();

    // Commit: higher score, then an equal score.
    pulse_inc(107);
    commit_chk(1'b0, 1'b1, 16'h0107);
    pulse_inc(150);
    commit_chk(1'b0, 1'b1, 16'h0150);
    pulse_inc(150);
    commit_chk(1'b0, 1'b0, 16'h0150);

    // Simultaneous inc and clear: pre-increment score is committed.
    @(negedge clk);
    async_reset();
    pulse_inc(99);
    commit_chk(1'b1, 1'b1, 16'h0099);

    // View timing: held button, then a re-trigger at view cycle 5.
    show_view(20, 0, f1, l1);
    chk("view_rise_edge", 64'(f1), 64'd3);
    chk("view_len", 64'(l1), 64'(SC));
    show_view(1, 2, f1, l1);
    chk("retrig_rise_edge", 64'(f1), 64'd3);
    chk("retrig_len", 64'(l1), 64'(SC + 4));

    // Score activity during a view does not disturb its timing.
    pulse_inc(100);
    fork
      show_view(1, 0, f1, l1);
      begin
        repeat (4) @(negedge clk);
        pulse_inc(3);
        commit_chk(1'b0, 1'b1, 16'h0103);
      end
    join
    chk("busy_view_rise", 64'(f1), 64'd3);
    chk("busy_view_len", 64'(l1), 64'(SC));

    // Counting and saturation.
    pulse_inc(1234);
    chk("count_1234", 64'(bcd), 64'h1234);
    pulse_inc(8765);
    chk("count_9999", 64'(bcd), 64'h9999);
    pulse_inc(5);
    chk("saturate", 64'(bcd), 64'h9999);
    commit_chk(1'b0, 1'b1, 16'h9999);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
